uart_tx_sequencer: RTL

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: 8N1 UART transmitter with per-frame latched bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] bit_period,
    input  logic [7:0]  data_in,
    input  logic        valid,
    output logic        ready,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state;
    logic [16:0] period;
    logic [16:0] timer;
    logic [7:0]  data;
    logic [2:0]  idx;
    logic        bit_end;

    assign bit_end = timer == period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            ready      <= 1'b1;
            frame_done <= 1'b0;
            timer      <= '0;
            idx        <= '0;
            period     <= '0;
            data       <= '0;
        end else begin
            frame_done <= 1'b0;
            // timer restarts at 1 on each bit boundary and never exceeds period
            if (state != IDLE)
                timer <= bit_end ? 17'd1 : timer + 17'd1;
            case (state)
                IDLE: if (valid && ready) begin
                    state  <= START;
                    tx     <= 1'b0;
                    busy   <= 1'b1;
                    ready  <= 1'b0;
                    timer  <= 17'd1;
                    idx    <= '0;
                    data   <= data_in;
                    period <= (bit_period == 17'd0) ? 17'd1 : bit_period;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= data[0];
                end
                DATA: if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= ^data;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        idx <= idx + 3'd1;
                        tx  <= data[idx + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bit_end) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (bit_end) begin
                    state      <= IDLE;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    ready      <= 1'b1;
                    frame_done <= 1'b1;
                    timer      <= '0;
                    idx        <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
